// File: rtl/brick_tile_map.sv
// Brick tile map: loads a per-tile health grid from an external ROM, draws
// non-empty tiles on the pixel scan and erodes tiles hit by rockets.
module brick_tile_map #(
  parameter int TILE_LOG2   = 5,
  parameter int COLS        = 20,
  parameter int ROWS        = 15,
  parameter int HP_W        = 2,
  parameter int NUM_ROCKETS = 2,
  parameter int X_MAX       = 543,
  parameter int Y_MAX       = 479,
  localparam int NCELL      = ROWS * COLS,
  localparam int AW         = $clog2(NCELL),
  localparam int BW         = $clog2(NCELL + 1)
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic [10:0]              pixelX,
  input  logic [10:0]              pixelY,
  input  logic                     load_req,
  output logic [AW-1:0]            map_addr,
  input  logic [HP_W-1:0]          map_rdata,
  input  logic [NUM_ROCKETS-1:0]   hit_valid,
  input  logic [NUM_ROCKETS*11-1:0] hit_x,
  input  logic [NUM_ROCKETS*11-1:0] hit_y,
  output logic                     drawingRequest,
  output logic [7:0]               RGBout,
  output logic [10:0]              offsetX,
  output logic [10:0]              offsetY,
  output logic                     busy,
  output logic                     map_done,
  output logic [NUM_ROCKETS-1:0]   hit_drop,
  output logic [BW-1:0]            bricks_left
);

  // state  | meaning
  // IDLE   | no map loaded, nothing drawn
  // LOAD   | streaming ROM into the cell grid, one address per cycle
  // ACTIVE | map drawn, rocket hits captured and serviced

  localparam int              CHW       = (NUM_ROCKETS > 1) ? $clog2(NUM_ROCKETS) : 1;
  localparam logic [10:0]     TILE_MASK = 11'((1 << TILE_LOG2) - 1);
  localparam logic [10:0]     X_LIM     = 11'(X_MAX);
  localparam logic [10:0]     Y_LIM     = 11'(Y_MAX);
  localparam logic [10:0]     COLS_T    = 11'(COLS);
  localparam logic [10:0]     ROWS_T    = 11'(ROWS);
  localparam logic [AW-1:0]   COLS_A    = AW'(COLS);
  localparam logic [BW-1:0]   LAST_CNT  = BW'(NCELL);
  localparam logic [BW-1:0]   LAST_ADDR = BW'(NCELL - 1);
  localparam logic [HP_W-1:0] HP_MAX    = '1;
  localparam logic [HP_W-1:0] HP_ONE    = HP_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  state_t                    state;
  logic [NCELL*HP_W-1:0]     cells;
  logic [BW-1:0]             load_cnt;
  logic [NUM_ROCKETS-1:0]    pending;
  logic [NUM_ROCKETS*11-1:0] pend_col;
  logic [NUM_ROCKETS*11-1:0] pend_row;

  logic [10:0]     px_col, px_row;
  logic            px_in;
  logic [AW-1:0]   px_idx;
  logic [HP_W-1:0] px_hp;
  logic            draw_c;
  logic [7:0]      rgb_c;

  assign px_col = pixelX >> TILE_LOG2;
  assign px_row = pixelY >> TILE_LOG2;
  assign px_in  = (px_col < COLS_T) && (px_row < ROWS_T);
  assign px_idx = AW'(px_row) * COLS_A + AW'(px_col);
  assign px_hp  = px_in ? cells[px_idx*HP_W +: HP_W] : '0;
  assign draw_c = (state == ACTIVE) && (px_hp != '0) &&
                  (pixelX != 11'd0) && (pixelX < X_LIM) &&
                  (pixelY != 11'd0) && (pixelY < Y_LIM);
  assign rgb_c  = (px_hp == HP_MAX) ? 8'hFF : 8'hB6;

  logic            svc_valid;
  logic [CHW-1:0]  svc_ch;
  logic [10:0]     svc_col, svc_row;
  logic            svc_in;
  logic [AW-1:0]   svc_idx;
  logic [HP_W-1:0] svc_hp;
  logic [AW-1:0]   wr_idx;

  // Descending scan so the lowest pending channel wins.
  always_comb begin
    svc_valid = 1'b0;
    svc_ch    = '0;
    for (int i = NUM_ROCKETS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        svc_valid = 1'b1;
        svc_ch    = CHW'(i);
      end
    end
  end

  assign svc_col = pend_col[svc_ch*11 +: 11];
  assign svc_row = pend_row[svc_ch*11 +: 11];
  assign svc_in  = (svc_col < COLS_T) && (svc_row < ROWS_T);
  assign svc_idx = AW'(svc_row) * COLS_A + AW'(svc_col);
  assign svc_hp  = svc_in ? cells[svc_idx*HP_W +: HP_W] : '0;
  assign wr_idx  = AW'(load_cnt - 1'b1);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state          <= IDLE;
      cells          <= '0;
      load_cnt       <= '0;
      pending        <= '0;
      pend_col       <= '0;
      pend_row       <= '0;
      map_addr       <= '0;
      busy           <= 1'b0;
      map_done       <= 1'b0;
      hit_drop       <= '0;
      bricks_left    <= '0;
      drawingRequest <= 1'b0;
      RGBout         <= 8'h00;
      offsetX        <= '0;
      offsetY        <= '0;
    end else begin
      map_done       <= 1'b0;
      hit_drop       <= '0;
      offsetX        <= pixelX & TILE_MASK;
      offsetY        <= pixelY & TILE_MASK;
      drawingRequest <= draw_c;
      RGBout         <= draw_c ? rgb_c : 8'h00;

      case (state)
        IDLE: begin
          if (load_req) begin
            state       <= LOAD;
            busy        <= 1'b1;
            load_cnt    <= '0;
            map_addr    <= '0;
            bricks_left <= '0;
            pending     <= '0;
          end
        end

        LOAD: begin
          // ROM data arriving now belongs to the address issued last cycle.
          if (load_cnt != '0) begin
            cells[wr_idx*HP_W +: HP_W] <= map_rdata;
            if (map_rdata != '0) bricks_left <= bricks_left + 1'b1;
          end
          if (load_cnt == LAST_CNT) begin
            state    <= ACTIVE;
            busy     <= 1'b0;
            map_done <= 1'b1;
            map_addr <= '0;
          end else begin
            load_cnt <= load_cnt + 1'b1;
            map_addr <= (load_cnt < LAST_ADDR) ? AW'(load_cnt + 1'b1) : '0;
          end
        end

        ACTIVE: begin
          if (load_req) begin
            state       <= LOAD;
            busy        <= 1'b1;
            load_cnt    <= '0;
            map_addr    <= '0;
            bricks_left <= '0;
            pending     <= '0;
          end else begin
            if (svc_valid) begin
              pending[svc_ch] <= 1'b0;
              if (svc_hp != '0) begin
                cells[svc_idx*HP_W +: HP_W] <= svc_hp - 1'b1;
                if (svc_hp == HP_ONE) bricks_left <= bricks_left - 1'b1;
              end
            end
            // A channel still holding an unserviced hit cannot take another.
            for (int i = 0; i < NUM_ROCKETS; i++) begin
              if (hit_valid[i]) begin
                if (pending[i]) begin
                  hit_drop[i] <= 1'b1;
                end else begin
                  pending[i]           <= 1'b1;
                  pend_col[i*11 +: 11] <= hit_x[i*11 +: 11] >> TILE_LOG2;
                  pend_row[i*11 +: 11] <= hit_y[i*11 +: 11] >> TILE_LOG2;
                end
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_tile_map.sv
// Directed bench for brick_tile_map: load timing, drawing, hit servicing,
// hit drops, drawable-area boundaries and reset during load.
module tb_brick_tile_map;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        load_req = 1'b0;
  logic [8:0]  map_addr;
  logic [1:0]  map_rdata = '0;
  logic [1:0]  hit_valid = '0;
  logic [21:0] hit_x = '0;
  logic [21:0] hit_y = '0;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic [10:0] offsetX, offsetY;
  logic        busy, map_done;
  logic [1:0]  hit_drop;
  logic [8:0]  bricks_left;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] rom [300];

  brick_tile_map dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .load_req(load_req), .map_addr(map_addr), .map_rdata(map_rdata),
    .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .drawingRequest(drawingRequest), .RGBout(RGBout),
    .offsetX(offsetX), .offsetY(offsetY), .busy(busy), .map_done(map_done),
    .hit_drop(hit_drop), .bricks_left(bricks_left)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears the cycle after it is driven.
  always @(posedge clk) map_rdata <= rom[map_addr];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 300; i++) rom[i] = 2'd0;
  endtask

  task automatic load_map(output int lat);
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    lat = 0;
    while (map_done !== 1'b1 && lat < 400) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic fire(input logic [1:0] v, input int x0, input int y0, input int x1, input int y1);
    hit_valid = v;
    hit_x = {11'(x1), 11'(x0)};
    hit_y = {11'(y1), 11'(y0)};
  endtask

  task automatic test_reset();
    resetN = 1'b0; pixelX = 11'd7; pixelY = 11'd9; load_req = 1'b0; hit_valid = '0;
    tick(3);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (map_done !== 1'b0) begin n_err++; $display("FAIL reset_map_done: got %b want 0", map_done); end
    n_cmp++; if (map_addr !== 9'd0) begin n_err++; $display("FAIL reset_map_addr: got %0d want 0", map_addr); end
    n_cmp++; if (bricks_left !== 9'd0) begin n_err++; $display("FAIL reset_bricks: got %0d want 0", bricks_left); end
    n_cmp++; if (drawingRequest !== 1'b0 || RGBout !== 8'h00) begin n_err++; $display("FAIL reset_draw: got %b/%h want 0/00", drawingRequest, RGBout); end
    n_cmp++; if (offsetX !== 11'd0 || offsetY !== 11'd0 || hit_drop !== 2'b00) begin n_err++; $display("FAIL reset_misc: got %0d/%0d/%b want 0/0/00", offsetX, offsetY, hit_drop); end
    resetN = 1'b1;
    tick(2);
    n_cmp++; if (busy !== 1'b0 || drawingRequest !== 1'b0) begin n_err++; $display("FAIL idle_outputs: got busy %b draw %b want 0/0", busy, drawingRequest); end
    n_cmp++; if (offsetX !== 11'd7 || offsetY !== 11'd9) begin n_err++; $display("FAIL idle_offset: got %0d/%0d want 7/9", offsetX, offsetY); end
  endtask

  task automatic test_load();
    int lat;
    clear_rom();
    rom[0] = 2'd1;
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    n_cmp++; if (busy !== 1'b1 || map_addr !== 9'd0) begin n_err++; $display("FAIL load_start: got busy %b addr %0d want 1/0", busy, map_addr); end
    tick(1);
    lat = 1;
    n_cmp++; if (map_addr !== 9'd1) begin n_err++; $display("FAIL load_addr1: got %0d want 1", map_addr); end
    while (map_done !== 1'b1 && lat < 400) begin
      tick(1);
      lat++;
    end
    n_cmp++; if (lat !== 301) begin n_err++; $display("FAIL load_latency: got %0d want 301", lat); end
    n_cmp++; if (busy !== 1'b0 || bricks_left !== 9'd1) begin n_err++; $display("FAIL load_done: got busy %b bricks %0d want 0/1", busy, bricks_left); end
    pixelX = 11'd5; pixelY = 11'd5;
    tick(1);
    n_cmp++; if (map_done !== 1'b0) begin n_err++; $display("FAIL map_done_pulse: got %b want 0", map_done); end
    n_cmp++; if (drawingRequest !== 1'b1 || RGBout !== 8'hB6) begin n_err++; $display("FAIL load_draw: got %b/%h want 1/b6", drawingRequest, RGBout); end
    n_cmp++; if (offsetX !== 11'd5) begin n_err++; $display("FAIL load_offset: got %0d want 5", offsetX); end
    pixelX = 11'd40;
    tick(1);
    n_cmp++; if (drawingRequest !== 1'b0) begin n_err++; $display("FAIL empty_cell: got %b want 0", drawingRequest); end
  endtask

  task automatic test_hit_sequence();
    int lat;
    logic [7:0] exp_rgb [3];
    logic       exp_dr [3];
    logic [8:0] exp_bricks [3];
    exp_rgb = '{8'hB6, 8'hB6, 8'h00};
    exp_dr = '{1'b1, 1'b1, 1'b0};
    exp_bricks = '{9'd2, 9'd2, 9'd1};
    clear_rom();
    rom[0] = 2'd3;
    rom[21] = 2'd2;
    load_map(lat);
    n_cmp++; if (map_done !== 1'b1 || bricks_left !== 9'd2) begin n_err++; $display("FAIL seq_load: got done %b bricks %0d want 1/2", map_done, bricks_left); end
    pixelX = 11'd5; pixelY = 11'd5;
    tick(1);
    n_cmp++; if (RGBout !== 8'hFF) begin n_err++; $display("FAIL seq_full: got %h want ff", RGBout); end
    for (int h = 0; h < 3; h++) begin
      fire(2'b01, 10, 10, 0, 0);
      tick(1);
      hit_valid = '0;
      tick(1);
      n_cmp++; if (bricks_left !== exp_bricks[h]) begin n_err++; $display("FAIL seq_bricks%0d: got %0d want %0d", h, bricks_left, exp_bricks[h]); end
      if (h == 0) begin
        n_cmp++; if (RGBout !== 8'hFF) begin n_err++; $display("FAIL seq_early: got %h want ff", RGBout); end
      end
      tick(1);
      n_cmp++; if (drawingRequest !== exp_dr[h] || RGBout !== exp_rgb[h]) begin n_err++; $display("FAIL seq_hit%0d: got %b/%h want %b/%h", h, drawingRequest, RGBout, exp_dr[h], exp_rgb[h]); end
    end
  endtask

  task automatic test_same_cycle_hits();
    pixelX = 11'd40; pixelY = 11'd40;
    fire(2'b11, 40, 40, 40, 40);
    tick(1);
    hit_valid = '0;
    n_cmp++; if (hit_drop !== 2'b00) begin n_err++; $display("FAIL dual_drop: got %b want 00", hit_drop); end
    tick(1);
    n_cmp++; if (bricks_left !== 9'd1 || RGBout !== 8'hB6) begin n_err++; $display("FAIL dual_t1: got bricks %0d rgb %h want 1/b6", bricks_left, RGBout); end
    tick(1);
    n_cmp++; if (bricks_left !== 9'd0 || drawingRequest !== 1'b1 || hit_drop !== 2'b00) begin n_err++; $display("FAIL dual_t2: got bricks %0d draw %b drop %b want 0/1/00", bricks_left, drawingRequest, hit_drop); end
    tick(1);
    n_cmp++; if (drawingRequest !== 1'b0) begin n_err++; $display("FAIL dual_cleared: got %b want 0", drawingRequest); end
  endtask

  task automatic test_hit_drop();
    fire(2'b11, 200, 200, 200, 200);
    tick(1);
    fire(2'b01, 200, 200, 200, 200);
    tick(1);
    n_cmp++; if (hit_drop !== 2'b01) begin n_err++; $display("FAIL drop_pulse: got %b want 01", hit_drop); end
    hit_valid = '0;
    tick(1);
    n_cmp++; if (hit_drop !== 2'b00) begin n_err++; $display("FAIL drop_clear: got %b want 00", hit_drop); end
    tick(1);
    hit_valid = 2'b01;
    tick(1);
    hit_valid = '0;
    n_cmp++; if (hit_drop !== 2'b00 || bricks_left !== 9'd0) begin n_err++; $display("FAIL drop_none: got %b bricks %0d want 00/0", hit_drop, bricks_left); end
    tick(2);
  endtask

  task automatic test_boundaries();
    int lat;
    int px [8];
    int py [8];
    logic ex [8];
    px = '{0, 543, 542, 5, 5, 5, 5, 40};
    py = '{5, 5, 5, 0, 1, 479, 478, 140};
    ex = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    clear_rom();
    rom[0] = 2'd3; rom[16] = 2'd3; rom[81] = 2'd1; rom[280] = 2'd3;
    load_map(lat);
    n_cmp++; if (lat !== 301 || bricks_left !== 9'd4) begin n_err++; $display("FAIL bnd_load: got lat %0d bricks %0d want 301/4", lat, bricks_left); end
    for (int i = 0; i < 8; i++) begin
      pixelX = 11'(px[i]); pixelY = 11'(py[i]);
      tick(1);
      n_cmp++; if (drawingRequest !== ex[i]) begin n_err++; $display("FAIL bnd_px(%0d,%0d): got %b want %b", px[i], py[i], drawingRequest, ex[i]); end
    end
    fire(2'b01, 700, 100, 0, 0);
    tick(1);
    hit_valid = '0;
    tick(3);
    n_cmp++; if (bricks_left !== 9'd4 || drawingRequest !== 1'b1 || RGBout !== 8'hB6) begin n_err++; $display("FAIL off_grid_hit: got bricks %0d draw %b rgb %h want 4/1/b6", bricks_left, drawingRequest, RGBout); end
  endtask

  task automatic test_reset_mid_load();
    logic drop_seen;
    logic draw_seen;
    drop_seen = 1'b0;
    draw_seen = 1'b0;
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      load_req = (k == 51);
      hit_valid = (k == 100) ? 2'b11 : ((k == 101) ? 2'b01 : 2'b00);
      tick(1);
      if (hit_drop !== 2'b00) drop_seen = 1'b1;
    end
    load_req = 1'b0;
    hit_valid = '0;
    n_cmp++; if (map_addr !== 9'd150 || busy !== 1'b1) begin n_err++; $display("FAIL mid_load_addr: got %0d busy %b want 150/1", map_addr, busy); end
    n_cmp++; if (drop_seen !== 1'b0) begin n_err++; $display("FAIL load_hit_drop: got %b want 0", drop_seen); end
    resetN = 1'b0;
    tick(1);
    resetN = 1'b1;
    n_cmp++; if (busy !== 1'b0 || bricks_left !== 9'd0 || map_addr !== 9'd0) begin n_err++; $display("FAIL mid_reset: got busy %b bricks %0d addr %0d want 0/0/0", busy, bricks_left, map_addr); end
    pixelX = 11'd5; pixelY = 11'd5;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (drawingRequest !== 1'b0) draw_seen = 1'b1;
    end
    n_cmp++; if (draw_seen !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL post_reset_draw: got %b busy %b want 0/0", draw_seen, busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    load_map(lat);
    n_cmp++; if (lat !== 301 || bricks_left !== 9'd4) begin n_err++; $display("FAIL reload: got lat %0d bricks %0d want 301/4", lat, bricks_left); end
    tick(1);
    n_cmp++; if (drawingRequest !== 1'b1 || RGBout !== 8'hFF) begin n_err++; $display("FAIL reload_draw: got %b/%h want 1/ff", drawingRequest, RGBout); end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_load();
    test_hit_sequence();
    test_same_cycle_hits();
    test_hit_drop();
    test_boundaries();
    test_reset_mid_load();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/brick_tile_map.md
BRICK_TILE_MAP -- requirements
Module: brick_tile_map

Interface
REQ-001 SHALL have parameter TILE_LOG2, default 5: tile edge is 2**TILE_LOG2 pixels.
REQ-002 SHALL have parameter COLS, default 20: tile columns.
REQ-003 SHALL have parameter ROWS, default 15: tile rows.
REQ-004 SHALL have parameter HP_W, default 2: per-tile health bits; 0 = empty.
REQ-005 SHALL have parameter NUM_ROCKETS, default 2: hit channels.
REQ-006 SHALL have parameters X_MAX = 543 and Y_MAX = 479: drawable-area bounds.
REQ-007 SHALL have port clk, input, 1: the only clock.
REQ-008 SHALL have port resetN, input, 1: reset, synchronous and active-low.
REQ-009 SHALL have ports pixelX, pixelY, input, 11 each: current scan pixel.
REQ-010 SHALL have port load_req, input, 1: pulse to start a map load.
REQ-011 SHALL have ports map_addr, output, clog2(ROWS*COLS), and map_rdata, input, HP_W: external map ROM, 1-cycle read latency.
REQ-012 SHALL have ports hit_valid, input, NUM_ROCKETS, and hit_x, hit_y, input, NUM_ROCKETS*11 packed: rocket impact pixel per channel.
REQ-013 SHALL have ports drawingRequest, output, 1, and RGBout, output, 8: tile pixel request and colour.
REQ-014 SHALL have ports offsetX, offsetY, output, 11: pixel offset inside the current tile.
REQ-015 SHALL have ports busy, output, 1; map_done, output, 1; hit_drop, output, NUM_ROCKETS; bricks_left, output, clog2(ROWS*COLS+1).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD and ACTIVE; busy = 1 only in LOAD.
REQ-017 SHALL move IDLE->LOAD or ACTIVE->LOAD on load_req=1; load_req in LOAD is ignored.
REQ-018 SHALL, in LOAD, drive map_addr 0..ROWS*COLS-1 row-major, one address per cycle, and write map_rdata into cell addr-1 on the following cycle.
REQ-019 SHALL pulse map_done for 1 cycle and enter ACTIVE on the cycle after the last cell is written; LOAD lasts ROWS*COLS+1 cycles.
REQ-020 SHALL set bricks_left to the count of nonzero cells loaded, valid in the map_done cycle.
REQ-021 SHALL compute tile index as col = pixelX>>TILE_LOG2 and row = pixelY>>TILE_LOG2.
REQ-022 SHALL register offsetX = pixelX & (2**TILE_LOG2-1) and offsetY likewise, 1-cycle latency.
REQ-023 SHALL register drawingRequest, with 1-cycle latency, as 1 iff state is ACTIVE, the cell health is nonzero, 0<pixelX<X_MAX, 0<pixelY<Y_MAX, col<COLS and row<ROWS.
REQ-024 SHALL register RGBout by health: max value 8'hFF, other nonzero values 8'hB6, 0 gives 8'h00; it is aligned with drawingRequest.
REQ-025 SHALL, in ACTIVE, capture each hit_valid[i] into a per-channel pending register together with the tile coordinates of hit_x/hit_y.
REQ-026 SHALL, when hit_valid[i] arrives while pending[i] is already set, drop the new hit and pulse hit_drop[i] for 1 cycle.
REQ-027 SHALL service one pending hit per cycle, lowest channel index first; a pending hit captured in cycle t is serviced no earlier than t+1.
REQ-028 SHALL, when servicing a hit, decrement the target cell's health saturating at 0.
REQ-029 SHALL decrement bricks_left when a serviced hit takes a cell from 1 to 0.
REQ-030 SHALL consume a hit on an empty or out-of-grid cell with no state change.
REQ-031 SHALL apply two hits on the same cell as two sequential decrements.
REQ-032 SHALL make a health update visible to drawingRequest from the cycle after it is serviced.
REQ-033 SHALL ignore hit_valid outside ACTIVE, without hit_drop; entering LOAD clears all pending hits.

Reset
REQ-034 SHALL, on a clk edge with resetN=0 in any state (including mid-LOAD), enter IDLE, clear all cells and pending hits, and drive every output to 0.
REQ-035 SHALL hold map_addr at 0 during reset and in IDLE.

Verification
REQ-036 Reset, then load_req with ROM returning 1 for cell 0 only -> map_done exactly 301 cycles later; bricks_left=1; pixel (5,5) gives drawingRequest=1, RGBout=8'h01 health -> 8'hB6 (HP_W=2), offsetX=5.
REQ-037 Cell (row 0, col 0) with health 3, hit ch0 at (10,10) three times, spaced -> health 3->2->1->0; RGBout FF, B6, B6; then drawingRequest=0; bricks_left decremented once.
REQ-038 Same-cycle hits on ch0 and ch1 to the same health-2 cell -> ch0 serviced at t+1, ch1 at t+2; cell becomes 0; no hit_drop.
REQ-039 ch0 hit in two consecutive cycles while ch1 is also pending -> second ch0 hit pulses hit_drop[0]=1.
REQ-040 Pixel (0,y), pixel (543,y) and pixel (x,0) over full cells -> drawingRequest=0; hit at (700,100) -> no state change.
REQ-041 resetN=0 at LOAD cycle 150 -> next cycle IDLE, busy=0, bricks_left=0, all drawingRequest=0 until the next completed load.
